id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have decode inputs: in_valid 1; in_rs_data/in_rt_data/in_imm 64 each; in_rs/in_rt/in_rd 5 each; in_operation 4 (ALU op code); in_shamt 5; in_alu_src 1 (1 = imm drives Op2); in_uses_rt 1; in_reg_write/in_mem_read/in_mem_write 1 each.
REQ-003 SHALL have control input flush 1 (taken branch/jump: discard instruction entering EX).
REQ-004 SHALL have forwarding inputs: exmem_reg_write 1, exmem_rd 5, exmem_result 64, memwb_reg_write 1, memwb_rd 5, memwb_result 64.
REQ-005 SHALL have outputs to ALU: Op1 64, Op2 64, operation 4, shamt 5.
REQ-006 SHALL have outputs: ex_valid 1, ex_rd 5, ex_reg_write 1, ex_mem_read 1, ex_mem_write 1, ex_store_data 64, stall 1 (hold PC and IF/ID).

Function
REQ-007 SHALL register on each rising clk edge, when not stalled/flushed, all in_* fields into stage registers (valid, rs/rt data, imm, rs, rt, rd, operation, shamt, alu_src, uses_rt, controls).
REQ-008 SHALL insert a bubble (valid=0, operation=4'h0, reg_write/mem_read/mem_write=0, rd=0) instead of capturing when flush=1 or stall=1.
REQ-009 SHALL give flush priority over stall; stall SHALL be 0 in any cycle flush=1.
REQ-010 SHALL drive stall combinationally = in_valid & ex_valid & ex_mem_read & ex_rd!=0 & (in_rs==ex_rd | (in_uses_rt & in_rt==ex_rd)) & ~flush.
REQ-011 SHALL produce exactly one bubble per load-use hazard; next cycle load is in MEM and stall clears unless a new hazard exists.
REQ-012 SHALL compute forwarded rs combinationally: exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==rs_q; else memwb_result if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs_q; else rs_data_q.
REQ-013 SHALL compute forwarded rt by the same rule using rt_q and rt_data_q; EX/MEM SHALL win over MEM/WB when both match.
REQ-014 SHALL never forward to register 0; operand for r0 SHALL be registered data (0 from register file).
REQ-015 SHALL drive Op1 = forwarded rs; Op2 = imm_q if alu_src_q else forwarded rt.
REQ-016 SHALL drive ex_store_data = forwarded rt regardless of alu_src_q.
REQ-017 SHALL drive operation/shamt/ex_rd/controls directly from stage registers; ALU subtract convention (Op2 - Op1) SHALL be preserved by placing rs on Op1, rt on Op2.
REQ-018 SHALL gate nothing on ex_valid in output muxing; bubble values of REQ-008 SHALL guarantee a no-op downstream.
REQ-019 SHALL add latency of exactly one cycle from decode input to ALU operands.

Reset
REQ-020 SHALL, while rst=1, asynchronously clear all stage registers to 0 (ex_valid=0, operation=4'h0, Op1/Op2 from zero data, controls 0); stall SHALL read 0.
REQ-021 SHALL, on rst asserted mid-operation, discard the in-flight instruction; first capture occurs on first rising edge after rst deasserts.

Verification
REQ-022 Reset: rst=1 with in_valid=1, in_operation=4'h4 -> ex_valid=0, operation=0, Op1=Op2=0, stall=0; after release next edge captures instruction.
REQ-023 Plain issue: in_rs_data=5, in_rt_data=7, in_alu_src=0, op 4'h4, no forwarding matches -> next cycle Op1=5, Op2=7, operation=4'h4.
REQ-024 Forward priority: rs_q=3, exmem_rd=3 result=0xAA, memwb_rd=3 result=0xBB, both reg_write=1 -> Op1=0xAA; drop exmem_reg_write -> Op1=0xBB; rs_q=0 with matching rd=0 -> Op1=rs_data_q.
REQ-025 Load-use: EX holds lw rd=8; in_rs=8 in_valid=1 -> stall=1 one cycle, bubble in EX (operation=0); next cycle stall=0, instruction captured, Op1=memwb_result once load reaches WB.
REQ-026 Flush+stall: hazard condition true and flush=1 same cycle -> stall=0, bubble captured, ex_valid=0.
REQ-027 Immediate/store: alu_src=1, imm=0x10, rt_q=4 with exmem_rd=4 result=0x99 -> Op2=0x10, ex_store_data=0x99.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decoded instruction, flush, forwarding taps and the EX-side outputs.
// master drives the decode/forwarding side; slave is the ID/EX stage itself.
interface id_ex_stage_if;
   logic        in_valid;
   logic [63:0] in_rs_data;
   logic [63:0] in_rt_data;
   logic [63:0] in_imm;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [3:0]  in_operation;
   logic [4:0]  in_shamt;
   logic        in_alu_src;
   logic        in_uses_rt;
   logic        in_reg_write;
   logic        in_mem_read;
   logic        in_mem_write;
   logic        flush;

   logic        exmem_reg_write;
   logic [4:0]  exmem_rd;
   logic [63:0] exmem_result;
   logic        memwb_reg_write;
   logic [4:0]  memwb_rd;
   logic [63:0] memwb_result;

   logic [63:0] Op1;
   logic [63:0] Op2;
   logic [3:0]  operation;
   logic [4:0]  shamt;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [63:0] ex_store_data;
   logic        stall;

   modport master (
      output in_valid, in_rs_data, in_rt_data, in_imm, in_rs, in_rt, in_rd,
             in_operation, in_shamt, in_alu_src, in_uses_rt, in_reg_write,
             in_mem_read, in_mem_write, flush,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_result,
      input  Op1, Op2, operation, shamt, ex_valid, ex_rd, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_store_data, stall
   );

   modport slave (
      input  in_valid, in_rs_data, in_rt_data, in_imm, in_rs, in_rt, in_rd,
             in_operation, in_shamt, in_alu_src, in_uses_rt, in_reg_write,
             in_mem_read, in_mem_write, flush,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_result,
      output Op1, Op2, operation, shamt, ex_valid, ex_rd, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_store_data, stall
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding; one cycle from decode to ALU operands.
// Load-use hazards raise stall (hold PC and IF/ID) and inject one bubble; flush overrides stall.
module id_ex_stage (
   input  logic           clk,
   input  logic           rst,
   id_ex_stage_if.slave   bus
);

   typedef struct packed {
      logic        valid;
      logic [63:0] rs_data;
      logic [63:0] rt_data;
      logic [63:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [3:0]  operation;
      logic [4:0]  shamt;
      logic        alu_src;
      logic        uses_rt;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
   } stage_t;

   stage_t      stage_q;
   stage_t      stage_d;
   logic        hazard;
   logic [63:0] rs_fwd;
   logic [63:0] rt_fwd;

   // EX/MEM is the younger producer, so it is checked first; r0 is never forwarded.
   function automatic logic [63:0] forward(
      input logic [4:0]  src,
      input logic [63:0] reg_data,
      input logic        xm_we,
      input logic [4:0]  xm_rd,
      input logic [63:0] xm_res,
      input logic        mw_we,
      input logic [4:0]  mw_rd,
      input logic [63:0] mw_res
   );
      logic [63:0] val;
      val = reg_data;
      if (xm_we && (xm_rd != 5'd0) && (xm_rd == src)) begin
         val = xm_res;
      end else if (mw_we && (mw_rd != 5'd0) && (mw_rd == src)) begin
         val = mw_res;
      end
      return val;
   endfunction

   always_comb begin
      hazard = bus.in_valid & stage_q.valid & stage_q.mem_read & (stage_q.rd != 5'd0)
             & ((bus.in_rs == stage_q.rd) | (bus.in_uses_rt & (bus.in_rt == stage_q.rd)))
             & ~bus.flush;
   end

   // A bubble is an all-zero stage: invalid, op 0, no writes, rd 0.
   always_comb begin
      stage_d = '0;
      if (!bus.flush && !hazard) begin
         stage_d.valid     = bus.in_valid;
         stage_d.rs_data   = bus.in_rs_data;
         stage_d.rt_data   = bus.in_rt_data;
         stage_d.imm       = bus.in_imm;
         stage_d.rs        = bus.in_rs;
         stage_d.rt        = bus.in_rt;
         stage_d.rd        = bus.in_rd;
         stage_d.operation = bus.in_operation;
         stage_d.shamt     = bus.in_shamt;
         stage_d.alu_src   = bus.in_alu_src;
         stage_d.uses_rt   = bus.in_uses_rt;
         stage_d.reg_write = bus.in_reg_write;
         stage_d.mem_read  = bus.in_mem_read;
         stage_d.mem_write = bus.in_mem_write;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   always_comb begin
      rs_fwd = forward(stage_q.rs, stage_q.rs_data,
                       bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                       bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
      rt_fwd = forward(stage_q.rt, stage_q.rt_data,
                       bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                       bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
   end

   // rs on Op1 and rt on Op2 keeps the ALU's Op2 - Op1 subtract ordering.
   assign bus.Op1           = rs_fwd;
   assign bus.Op2           = stage_q.alu_src ? stage_q.imm : rt_fwd;
   assign bus.ex_store_data = rt_fwd;
   assign bus.operation     = stage_q.operation;
   assign bus.shamt         = stage_q.shamt;
   assign bus.ex_valid      = stage_q.valid;
   assign bus.ex_rd         = stage_q.rd;
   assign bus.ex_reg_write  = stage_q.reg_write;
   assign bus.ex_mem_read   = stage_q.mem_read;
   assign bus.ex_mem_write  = stage_q.mem_write;
   assign bus.stall         = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for capture/forwarding, hand sequences for reset and hazards.
module tb_id_ex_stage;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic        valid;
      logic [3:0]  op;
      logic        alu_src;
      logic        uses_rt;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [63:0] rs_data;
      logic [63:0] rt_data;
      logic [63:0] imm;
      logic        xm_we;
      logic [4:0]  xm_rd;
      logic [63:0] xm_res;
      logic        mw_we;
      logic [4:0]  mw_rd;
      logic [63:0] mw_res;
      logic        chk_ops;
      logic        e_valid;
      logic [3:0]  e_op;
      logic [4:0]  e_rd;
      logic [63:0] e_op1;
      logic [63:0] e_op2;
      logic [63:0] e_store;
   } vec_t;

   localparam int NVEC = 10;
   vec_t vec [NVEC];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      bus.in_valid        = 1'b0;
      bus.in_rs_data      = 64'h0;
      bus.in_rt_data      = 64'h0;
      bus.in_imm          = 64'h0;
      bus.in_rs           = 5'd0;
      bus.in_rt           = 5'd0;
      bus.in_rd           = 5'd0;
      bus.in_operation    = 4'h0;
      bus.in_shamt        = 5'd0;
      bus.in_alu_src      = 1'b0;
      bus.in_uses_rt      = 1'b0;
      bus.in_reg_write    = 1'b0;
      bus.in_mem_read     = 1'b0;
      bus.in_mem_write    = 1'b0;
      bus.flush           = 1'b0;
      bus.exmem_reg_write = 1'b0;
      bus.exmem_rd        = 5'd0;
      bus.exmem_result    = 64'h0;
      bus.memwb_reg_write = 1'b0;
      bus.memwb_rd        = 5'd0;
      bus.memwb_result    = 64'h0;
   endtask

   // Put a valid load writing rd into the decode inputs.
   task automatic drive_load(input logic [4:0] rd);
      clear_inputs();
      bus.in_valid     = 1'b1;
      bus.in_mem_read  = 1'b1;
      bus.in_reg_write = 1'b1;
      bus.in_rd        = rd;
      bus.in_rs        = 5'd1;
      bus.in_rs_data   = 64'h100;
      bus.in_operation = 4'h2;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;

      //            fl    vl    op    src   urt   rs     rt     rd     rs_data      rt_data      imm                     xwe   xrd    xres          mwe   mrd    mres          ck    ev    eop   erd    eop1          eop2                    estore
      vec[0] = '{1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 5'd1,  5'd2,  5'd3,  64'h5,       64'h7,       64'h0,                  1'b0, 5'd0,  64'h0,        1'b0, 5'd0,  64'h0,        1'b1, 1'b1, 4'h4, 5'd3,  64'h5,        64'h7,                  64'h7};
      vec[1] = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 5'd3,  5'd5,  5'd4,  64'h11,      64'h22,      64'h0,                  1'b1, 5'd3,  64'hAA,       1'b1, 5'd3,  64'hBB,       1'b1, 1'b1, 4'h2, 5'd4,  64'hAA,       64'h22,                 64'h22};
      vec[2] = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 5'd3,  5'd5,  5'd4,  64'h11,      64'h22,      64'h0,                  1'b0, 5'd3,  64'hAA,       1'b1, 5'd3,  64'hBB,       1'b1, 1'b1, 4'h2, 5'd4,  64'hBB,       64'h22,                 64'h22};
      vec[3] = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 5'd0,  5'd0,  5'd6,  64'h33,      64'h44,      64'h0,                  1'b1, 5'd0,  64'hAA,       1'b1, 5'd0,  64'hBB,       1'b1, 1'b1, 4'h3, 5'd6,  64'h33,       64'h44,                 64'h44};
      vec[4] = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 5'd6,  5'd4,  5'd7,  64'h6,       64'h55,      64'h10,                 1'b1, 5'd4,  64'h99,       1'b0, 5'd0,  64'h0,        1'b1, 1'b1, 4'h1, 5'd7,  64'h6,        64'h10,                 64'h99};
      vec[5] = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 5'd10, 5'd7,  5'd8,  64'hA0,      64'h70,      64'h0,                  1'b1, 5'd11, 64'hEE,       1'b1, 5'd7,  64'h77,       1'b1, 1'b1, 4'h5, 5'd8,  64'hA0,       64'h77,                 64'h77};
      vec[6] = '{1'b0, 1'b1, 4'h6, 1'b0, 1'b1, 5'd12, 5'd9,  5'd13, 64'hC0,      64'h90,      64'h0,                  1'b1, 5'd9,  64'h900,      1'b1, 5'd9,  64'h901,      1'b1, 1'b1, 4'h6, 5'd13, 64'hC0,       64'h900,                64'h900};
      vec[7] = '{1'b1, 1'b1, 4'h4, 1'b0, 1'b1, 5'd3,  5'd5,  5'd4,  64'h11,      64'h22,      64'h0,                  1'b0, 5'd0,  64'h0,        1'b0, 5'd0,  64'h0,        1'b0, 1'b0, 4'h0, 5'd0,  64'h0,        64'h0,                  64'h0};
      vec[8] = '{1'b0, 1'b0, 4'h7, 1'b0, 1'b1, 5'd2,  5'd3,  5'd14, 64'h1,       64'h2,       64'h0,                  1'b0, 5'd0,  64'h0,        1'b0, 5'd0,  64'h0,        1'b1, 1'b0, 4'h7, 5'd14, 64'h1,        64'h2,                  64'h2};
      vec[9] = '{1'b0, 1'b1, 4'h8, 1'b1, 1'b1, 5'd15, 5'd16, 5'd17, 64'h5,       64'h6,       64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 5'd15, 64'h1515,     1'b1, 5'd16, 64'h1616,     1'b1, 1'b1, 4'h8, 5'd17, 64'h1515,     64'hFFFF_FFFF_FFFF_FFF0, 64'h1616};

      // Reset held with a valid instruction presented.
      clear_inputs();
      rst              = 1'b1;
      bus.in_valid     = 1'b1;
      bus.in_operation = 4'h4;
      bus.in_rs        = 5'd1;
      bus.in_rt        = 5'd2;
      bus.in_rs_data   = 64'h5;
      bus.in_rt_data   = 64'h7;
      bus.in_uses_rt   = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset ex_valid", bus.ex_valid, 1'b0);
      chk("reset operation", bus.operation, 4'h0);
      chk("reset Op1", bus.Op1, 64'h0);
      chk("reset Op2", bus.Op2, 64'h0);
      chk("reset stall", bus.stall, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("post-reset ex_valid", bus.ex_valid, 1'b1);
      chk("post-reset operation", bus.operation, 4'h4);
      chk("post-reset Op1", bus.Op1, 64'h5);
      chk("post-reset Op2", bus.Op2, 64'h7);

      // Vector table: drive on negedge, capture on posedge, check at next negedge.
      for (int i = 0; i < NVEC; i++) begin
         clear_inputs();
         bus.flush           = vec[i].flush;
         bus.in_valid        = vec[i].valid;
         bus.in_operation    = vec[i].op;
         bus.in_alu_src      = vec[i].alu_src;
         bus.in_uses_rt      = vec[i].uses_rt;
         bus.in_rs           = vec[i].rs;
         bus.in_rt           = vec[i].rt;
         bus.in_rd           = vec[i].rd;
         bus.in_rs_data      = vec[i].rs_data;
         bus.in_rt_data      = vec[i].rt_data;
         bus.in_imm          = vec[i].imm;
         bus.in_shamt        = 5'(i + 1);
         bus.in_reg_write    = 1'b1;
         bus.exmem_reg_write = vec[i].xm_we;
         bus.exmem_rd        = vec[i].xm_rd;
         bus.exmem_result    = vec[i].xm_res;
         bus.memwb_reg_write = vec[i].mw_we;
         bus.memwb_rd        = vec[i].mw_rd;
         bus.memwb_result    = vec[i].mw_res;
         #1;
         chk($sformatf("v%0d stall", i), bus.stall, 1'b0);
         @(negedge clk);
         chk($sformatf("v%0d ex_valid", i), bus.ex_valid, vec[i].e_valid);
         chk($sformatf("v%0d operation", i), bus.operation, vec[i].e_op);
         chk($sformatf("v%0d ex_rd", i), bus.ex_rd, vec[i].e_rd);
         chk($sformatf("v%0d ex_reg_write", i), bus.ex_reg_write, !vec[i].flush);
         chk($sformatf("v%0d shamt", i), bus.shamt, vec[i].flush ? 5'd0 : 5'(i + 1));
         if (vec[i].chk_ops) begin
            chk($sformatf("v%0d Op1", i), bus.Op1, vec[i].e_op1);
            chk($sformatf("v%0d Op2", i), bus.Op2, vec[i].e_op2);
            chk($sformatf("v%0d store", i), bus.ex_store_data, vec[i].e_store);
         end
      end

      // Load-use: lw r8 in EX, consumer reads r8.
      drive_load(5'd8);
      @(negedge clk);
      clear_inputs();
      bus.in_valid     = 1'b1;
      bus.in_rs        = 5'd8;
      bus.in_rt        = 5'd2;
      bus.in_uses_rt   = 1'b1;
      bus.in_rt_data   = 64'h3;
      bus.in_rd        = 5'd9;
      bus.in_reg_write = 1'b1;
      bus.in_operation = 4'h4;
      #1;
      chk("lu stall", bus.stall, 1'b1);
      @(negedge clk);
      chk("lu bubble ex_valid", bus.ex_valid, 1'b0);
      chk("lu bubble operation", bus.operation, 4'h0);
      chk("lu bubble mem_read", bus.ex_mem_read, 1'b0);
      chk("lu stall cleared", bus.stall, 1'b0);
      bus.exmem_reg_write = 1'b1;
      bus.exmem_rd        = 5'd8;
      bus.exmem_result    = 64'h5555;
      @(negedge clk);
      bus.exmem_reg_write = 1'b0;
      bus.memwb_reg_write = 1'b1;
      bus.memwb_rd        = 5'd8;
      bus.memwb_result    = 64'hDEAD;
      #1;
      chk("lu consumer ex_valid", bus.ex_valid, 1'b1);
      chk("lu consumer operation", bus.operation, 4'h4);
      chk("lu consumer Op1", bus.Op1, 64'hDEAD);
      chk("lu consumer Op2", bus.Op2, 64'h3);
      chk("lu no stall", bus.stall, 1'b0);

      // Hazard via rt, gated by uses_rt, then overridden by flush.
      @(negedge clk);
      drive_load(5'd8);
      @(negedge clk);
      clear_inputs();
      bus.in_valid     = 1'b1;
      bus.in_rs        = 5'd4;
      bus.in_rt        = 5'd8;
      bus.in_uses_rt   = 1'b1;
      bus.in_operation = 4'h4;
      bus.in_rd        = 5'd10;
      bus.in_reg_write = 1'b1;
      #1;
      chk("rt hazard stall", bus.stall, 1'b1);
      bus.in_uses_rt = 1'b0;
      #1;
      chk("rt unused stall", bus.stall, 1'b0);
      bus.in_uses_rt = 1'b1;
      bus.flush      = 1'b1;
      #1;
      chk("flush+hazard stall", bus.stall, 1'b0);
      @(negedge clk);
      chk("flush bubble ex_valid", bus.ex_valid, 1'b0);
      chk("flush bubble operation", bus.operation, 4'h0);
      chk("flush bubble ex_rd", bus.ex_rd, 5'd0);

      // Load to r0 never creates a hazard.
      drive_load(5'd0);
      @(negedge clk);
      clear_inputs();
      bus.in_valid = 1'b1;
      bus.in_rs    = 5'd0;
      #1;
      chk("r0 load stall", bus.stall, 1'b0);

      // Reset asserted mid-cycle discards the in-flight instruction.
      @(negedge clk);
      clear_inputs();
      bus.in_valid     = 1'b1;
      bus.in_operation = 4'h9;
      bus.in_rs_data   = 64'h42;
      @(negedge clk);
      chk("pre-reset ex_valid", bus.ex_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("async reset ex_valid", bus.ex_valid, 1'b0);
      chk("async reset operation", bus.operation, 4'h0);
      @(negedge clk);
      chk("held reset ex_valid", bus.ex_valid, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("recapture ex_valid", bus.ex_valid, 1'b1);
      chk("recapture operation", bus.operation, 4'h9);
      chk("recapture Op1", bus.Op1, 64'h42);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
